// File: rtl/minus_seq_pkg.sv
// Shared types and constants for the minus_seq multi-word subtraction sequencer.
package minus_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StFire,
    StWait,
    StDone
  } state_e;

  localparam int unsigned SYNC_DEPTH = 2;
  localparam int unsigned GUARD_CYC  = 2;

endpackage

// File: rtl/fin_sync.sv
// Multi-flop synchronizer for the self-timed fin strobe; resets high to match fin idle.
module fin_sync
  import minus_seq_pkg::*;
#(
  parameter int unsigned Depth = SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [Depth-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[Depth-2:0], d};
    end
  end

  assign q = sync_q[Depth-1];

endmodule

// File: rtl/minus_seq.sv
// Issues K chained N-bit requests to the self-timed minus stage to compute A - B - bin.
// Optional WAIT timeout abort is enabled by defining MINUS_SEQ_TIMEOUT_EN.
module minus_seq
  import minus_seq_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned K   = 4,
  parameter int unsigned TMO = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           bin,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] diff,
  output logic           bout,
  output logic           err,
  output logic           m_req,
  output logic [N-1:0]   m_x,
  output logic [N-1:0]   m_y,
  output logic           m_cin,
  input  logic           m_fin,
  input  logic [N-1:0]   m_so,
  input  logic           m_couto
);

  localparam int unsigned IdxW   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned GuardW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(K - 1);
  localparam logic [GuardW-1:0] LastGuard = GuardW'(GUARD_CYC - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, nxt_idx;
  logic [GuardW-1:0] guard_q;
  logic [N*K-1:0]    a_q, b_q, diff_q;
  logic              borrow_q, bout_q, err_q, m_req_q, m_cin_q;
  logic [N-1:0]      m_x_q, m_y_q;
  logic              fin_s, accept, capture, abort, timeout_hit;

  fin_sync #(
    .Depth(SYNC_DEPTH)
  ) u_fin_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (m_fin),
    .q    (fin_s)
  );

  assign nxt_idx = idx_q + 1'b1;

`ifdef MINUS_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TMO + 1);

  logic [TmoW-1:0] wait_cnt_q;

  // Last allowed WAIT cycle; abort if fin is still low at its end.
  assign timeout_hit = (wait_cnt_q == TmoW'(TMO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q != StWait) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^TMO;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // fin low here means a previous request is still in flight.
        if (start && fin_s) begin
          accept  = 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: state_d = StFire;
      StFire: begin
        if (guard_q == LastGuard) state_d = StWait;
      end
      StWait: begin
        if (fin_s) begin
          capture = 1'b1;
          state_d = (idx_q == LastIdx) ? StDone : StSetup;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      guard_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      err_q    <= 1'b0;
      m_req_q  <= 1'b0;
      m_x_q    <= '0;
      m_y_q    <= '0;
      m_cin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Operands for the next word are loaded on entry to SETUP so they settle before req.
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        idx_q   <= '0;
        err_q   <= 1'b0;
        diff_q  <= '0;
        m_x_q   <= a[N-1:0];
        m_y_q   <= b[N-1:0];
        m_cin_q <= bin;
      end
      if (state_q == StSetup) begin
        m_req_q <= 1'b1;
        guard_q <= '0;
      end
      if (state_q == StFire) begin
        guard_q <= guard_q + 1'b1;
      end
      if (capture) begin
        diff_q[idx_q*N +: N] <= m_so;
        borrow_q             <= m_couto;
        m_req_q              <= 1'b0;
        if (idx_q == LastIdx) begin
          bout_q <= m_couto;
        end else begin
          idx_q   <= nxt_idx;
          m_x_q   <= a_q[nxt_idx*N +: N];
          m_y_q   <= b_q[nxt_idx*N +: N];
          m_cin_q <= m_couto;
        end
      end
      if (abort) begin
        m_req_q <= 1'b0;
        err_q   <= 1'b1;
        bout_q  <= borrow_q;
      end
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);
  assign diff  = diff_q;
  assign bout  = bout_q;
  assign err   = err_q;
  assign m_req = m_req_q;
  assign m_x   = m_x_q;
  assign m_y   = m_y_q;
  assign m_cin = m_cin_q;

endmodule

// File: tb/tb_minus_seq.sv
// Bench for minus_seq (N=32, K=2) with a behavioural self-timed minus stage model.
`timescale 1ns/1ps
module tb_minus_seq;
  localparam int unsigned N = 32;
  localparam int unsigned K = 2;
  localparam int unsigned W = N * K;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, bout, err, m_req, m_cin;
  logic [W-1:0] diff;
  logic [N-1:0] m_x, m_y;
  logic         m_fin = 1'b1;
  logic [N-1:0] m_so = '0;
  logic         m_couto = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int fin_delay = 3;
  bit fin_stuck = 1'b0;
  logic cin_log[$];

  always #5 clk = ~clk;

  minus_seq #(.N(N), .K(K), .TMO(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .bout   (bout),
    .err    (err),
    .m_req  (m_req),
    .m_x    (m_x),
    .m_y    (m_y),
    .m_cin  (m_cin),
    .m_fin  (m_fin),
    .m_so   (m_so),
    .m_couto(m_couto)
  );

  // Self-timed minus stage: fin drops on req rise and returns after fin_delay ns.
  always begin
    logic [N-1:0] x, y;
    logic         c;
    logic [N:0]   r;
    @(posedge m_req);
    x = m_x;
    y = m_y;
    c = m_cin;
    cin_log.push_back(m_cin);
    m_fin = 1'b0;
    #(fin_delay);
    wait (!fin_stuck);
    r = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, c};
    m_so = r[N-1:0];
    m_couto = r[N];
    m_fin = 1'b1;
  end

  function automatic logic [W:0] ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic bi);
    ref_sub = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
  endfunction

  // Cycles per word: fin must be seen by the second sync flop, never fewer than 4.
  function automatic int exp_lat(input int d);
    int c;
    c = (d + 9) / 10;
    exp_lat = K * ((c + 3 > 4) ? c + 3 : 4);
  endfunction

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                       output int lat, output int req_cyc);
    @(negedge clk);
    a = av;
    b = bv;
    bin = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    req_cyc = 0;
    while (done !== 1'b1 && lat < 2000) begin
      if (m_req === 1'b1) req_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({busy, done, err, bout, m_req, m_cin} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000", {busy, done, err, bout, m_req, m_cin});
    end
    n_cmp++;
    if ({diff, m_x, m_y} !== {(W + 2 * N){1'b0}}) begin
      n_fail++;
      $display("FAIL reset_data: got diff=%h x=%h y=%h want 0", diff, m_x, m_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, rc;
    fin_delay = 3;
    do_op(64'h0000_0001_0000_0000, 64'd1, 1'b0, lat, rc);
    n_cmp++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_cmp++;
    if (diff !== 64'h0000_0000_FFFF_FFFF) begin
      n_fail++; $display("FAIL basic_diff: got %h want 00000000ffffffff", diff);
    end
    n_cmp++;
    if (bout !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL basic_bout_err: got %b%b want 00", bout, err);
    end
    n_cmp++;
    if (rc !== 6) begin n_fail++; $display("FAIL basic_req_cycles: got %0d want 6", rc); end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL basic_after_done: got busy,done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_borrow();
    int lat, rc;
    cin_log.delete();
    do_op(64'd0, 64'd1, 1'b0, lat, rc);
    n_cmp++;
    if (diff !== 64'hFFFF_FFFF_FFFF_FFFF || bout !== 1'b1) begin
      n_fail++; $display("FAIL borrow_result: got %h/%b want ffffffffffffffff/1", diff, bout);
    end
    n_cmp++;
    if (cin_log.size() != 2 || cin_log[0] !== 1'b0 || cin_log[1] !== 1'b1) begin
      n_fail++; $display("FAIL borrow_chain: got %0d reqs cin=%p want 2 reqs 0,1",
                         cin_log.size(), cin_log);
    end
  endtask

  task automatic test_mid_start();
    int lat;
    logic held;
    logic [2*N:0] snap;
    held = 1'b0;
    snap = '0;
    @(negedge clk);
    a = 64'd5;
    b = 64'd2;
    bin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      start = (lat == 2 || lat == 5);
      if (lat == 2) begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
      if (m_req === 1'b1) begin
        if (!held) snap = {m_x, m_y, m_cin};
        else begin
          n_cmp++;
          if ({m_x, m_y, m_cin} !== snap) begin
            n_fail++; $display("FAIL req_stable: got %h want %h", {m_x, m_y, m_cin}, snap);
          end
        end
        held = 1'b1;
      end else held = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_cmp++;
    if (lat !== 8 || diff !== 64'd2 || bout !== 1'b0) begin
      n_fail++; $display("FAIL mid_start: got lat=%0d diff=%h bout=%b want 8/2/0", lat, diff, bout);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_start_idle: got busy=%b want 0", busy); end
    end
  endtask

  task automatic test_slow_fin();
    int lat, rc;
    fin_delay = 101;
    do_op(64'h0000_0001_0000_0000, 64'd1, 1'b0, lat, rc);
    n_cmp++;
    if (lat !== 28 || diff !== 64'h0000_0000_FFFF_FFFF || bout !== 1'b0) begin
      n_fail++; $display("FAIL slow_fin: got lat=%0d diff=%h bout=%b want 28/ffffffff/0",
                         lat, diff, bout);
    end
    n_cmp++;
    if (rc !== 26) begin n_fail++; $display("FAIL slow_req_cycles: got %0d want 26", rc); end
    fin_delay = 3;
  endtask

  task automatic test_random();
    int lat, rc, d;
    int delays[4] = '{3, 17, 44, 101};
    logic [W-1:0] av, bv;
    logic bi;
    logic [W:0] r;
    for (int i = 0; i < 10; i++) begin
      av = {$urandom, $urandom};
      bv = (i == 0) ? av : {$urandom, $urandom};
      bi = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (i == 1) begin av = '1; bv = '0; end
      if (i == 2) begin bv = av; bi = 1'b0; end
      d = delays[$urandom_range(0, 3)];
      fin_delay = d;
      r = ref_sub(av, bv, bi);
      do_op(av, bv, bi, lat, rc);
      n_cmp++;
      if (diff !== r[W-1:0] || bout !== r[W]) begin
        n_fail++; $display("FAIL rand_result[%0d]: got %h/%b want %h/%b", i, diff, bout,
                           r[W-1:0], r[W]);
      end
      n_cmp++;
      if (lat !== exp_lat(d)) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d (delay %0d)", i, lat,
                           exp_lat(d), d);
      end
    end
    fin_delay = 3;
  endtask

  task automatic test_reset_mid();
    int lat, rc, waited;
    logic [W:0] r;
    fin_delay = 101;
    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'h0FED_CBA9_8765_4321;
    bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, err, bout, m_req, m_cin} !== 6'b0 || {diff, m_x, m_y} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got ctrl=%b diff=%h x=%h y=%h want 0",
                         {busy, done, err, bout, m_req, m_cin}, diff, m_x, m_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL inflight_start: got busy=%b want 0", busy); end
      @(negedge clk);
    end
    waited = 0;
    while (m_fin !== 1'b1 && waited < 50) begin @(negedge clk); waited++; end
    n_cmp++;
    if (m_fin !== 1'b1) begin n_fail++; $display("FAIL model_fin: got %b want 1", m_fin); end
    repeat (3) @(negedge clk);
    fin_delay = 3;
    r = ref_sub(64'hFFFF_0000_1111_2222, 64'h0000_FFFF_2222_1111, 1'b1);
    do_op(64'hFFFF_0000_1111_2222, 64'h0000_FFFF_2222_1111, 1'b1, lat, rc);
    n_cmp++;
    if (lat !== 8 || diff !== r[W-1:0] || bout !== r[W]) begin
      n_fail++; $display("FAIL after_reset_op: got lat=%0d %h/%b want 8 %h/%b", lat, diff, bout,
                         r[W-1:0], r[W]);
    end
  endtask

`ifdef MINUS_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int lat, rc;
    fin_stuck = 1'b1;
    do_op(64'h0000_0003_0000_0007, 64'd1, 1'b0, lat, rc);
    n_cmp++;
    if (lat !== 19 || err !== 1'b1 || m_req !== 1'b0 || diff !== '0) begin
      n_fail++; $display("FAIL timeout: got lat=%0d err=%b req=%b diff=%h want 19/1/0/0",
                         lat, err, m_req, diff);
    end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_mid_start();
    test_slow_fin();
    test_random();
    test_reset_mid();
`ifdef MINUS_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
